// File: rtl/icb_pkg.sv
// Shared ICB definitions for the splitter: field widths, the error-target response
// constants and the helper that sizes the port-id field.
package icb_pkg;

    localparam int unsigned ICB_SIZE_W = 2;

    // Fixed response presented by the built-in error target.
    localparam logic ERR_RSP_ERR = 1'b1;
    localparam logic ERR_RSP_EXCL_OK = 1'b0;
    localparam logic [1023:0] ERR_RDATA = '0;

    // Port-id width able to encode every target plus the error target.
    function automatic int unsigned splt_ptr_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/icb_splt_addr_dec.sv
// Base/mask address decoder for the ICB splitter.
// The lowest-index matching region wins; a miss selects the error target.
module icb_splt_addr_dec #(
    parameter int unsigned AW = 32,
    parameter int unsigned SPLT_NUM = 2,
    parameter int unsigned SPLT_PTR_W = 2,
    parameter logic [SPLT_NUM*AW-1:0] REGION_BASE = '0,
    parameter logic [SPLT_NUM*AW-1:0] REGION_MASK = '0
) (
    input  logic [AW-1:0]         addr,
    output logic [SPLT_PTR_W-1:0] dec_id
);

    always_comb begin
        dec_id = SPLT_PTR_W'(SPLT_NUM);
        // Walk downwards so the lowest matching index is the final assignment.
        for (int k = SPLT_NUM - 1; k >= 0; k--) begin
            if ((addr & REGION_MASK[k*AW +: AW]) ==
                (REGION_BASE[k*AW +: AW] & REGION_MASK[k*AW +: AW])) begin
                dec_id = SPLT_PTR_W'(k);
            end
        end
    end

endmodule

// File: rtl/icb_splt_e203.sv
// 1-to-N ICB splitter: routes commands by address, returns responses in order, and
// answers unmapped addresses from a built-in error target.
module icb_splt_e203
    import icb_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned USR_W = 1,
    parameter int unsigned SPLT_NUM = 2,
    parameter int unsigned SPLT_PTR_W = 2,
    parameter int unsigned OUTS_NUM = 1,
    parameter int unsigned OUTS_CNT_W = 3,
    parameter logic [SPLT_NUM*AW-1:0] REGION_BASE = '0,
    parameter logic [SPLT_NUM*AW-1:0] REGION_MASK = '0,
    parameter bit ALLOW_0CYCL_RSP = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic                             i_icb_cmd_valid,
    output logic                             i_icb_cmd_ready,
    input  logic                             i_icb_cmd_read,
    input  logic [AW-1:0]                    i_icb_cmd_addr,
    input  logic [DW-1:0]                    i_icb_cmd_wdata,
    input  logic [DW/8-1:0]                  i_icb_cmd_wmask,
    input  logic [ICB_SIZE_W-1:0]            i_icb_cmd_size,
    input  logic                             i_icb_cmd_lock,
    input  logic                             i_icb_cmd_excl,
    input  logic [USR_W-1:0]                 i_icb_cmd_usr,

    output logic                             i_icb_rsp_valid,
    input  logic                             i_icb_rsp_ready,
    output logic                             i_icb_rsp_err,
    output logic                             i_icb_rsp_excl_ok,
    output logic [DW-1:0]                    i_icb_rsp_rdata,
    output logic [USR_W-1:0]                 i_icb_rsp_usr,

    output logic [SPLT_NUM-1:0]              o_bus_icb_cmd_valid,
    input  logic [SPLT_NUM-1:0]              o_bus_icb_cmd_ready,
    output logic [SPLT_NUM-1:0]              o_bus_icb_cmd_read,
    output logic [SPLT_NUM*AW-1:0]           o_bus_icb_cmd_addr,
    output logic [SPLT_NUM*DW-1:0]           o_bus_icb_cmd_wdata,
    output logic [SPLT_NUM*DW/8-1:0]         o_bus_icb_cmd_wmask,
    output logic [SPLT_NUM*ICB_SIZE_W-1:0]   o_bus_icb_cmd_size,
    output logic [SPLT_NUM-1:0]              o_bus_icb_cmd_lock,
    output logic [SPLT_NUM-1:0]              o_bus_icb_cmd_excl,
    output logic [SPLT_NUM*USR_W-1:0]        o_bus_icb_cmd_usr,

    input  logic [SPLT_NUM-1:0]              o_bus_icb_rsp_valid,
    output logic [SPLT_NUM-1:0]              o_bus_icb_rsp_ready,
    input  logic [SPLT_NUM-1:0]              o_bus_icb_rsp_err,
    input  logic [SPLT_NUM-1:0]              o_bus_icb_rsp_excl_ok,
    input  logic [SPLT_NUM*DW-1:0]           o_bus_icb_rsp_rdata,
    input  logic [SPLT_NUM*USR_W-1:0]        o_bus_icb_rsp_usr
);

    localparam logic [SPLT_PTR_W-1:0] ERR_ID = SPLT_PTR_W'(SPLT_NUM);
    localparam logic [OUTS_CNT_W-1:0] OUTS_MAX = OUTS_CNT_W'(OUTS_NUM);

    logic [SPLT_PTR_W-1:0] dec_id;
    logic [SPLT_PTR_W-1:0] cur_id;
    logic [SPLT_PTR_W-1:0] rsp_id;
    logic [OUTS_CNT_W-1:0] outs_cnt;
    logic                  err_pend;
    logic [USR_W-1:0]      err_usr;
    logic                  cnt_zero;
    logic                  stall;
    logic                  tgt_ready;
    logic                  cmd_hs;
    logic                  rsp_open;
    logic                  rsp_hs;

    icb_splt_addr_dec #(
        .AW          (AW),
        .SPLT_NUM    (SPLT_NUM),
        .SPLT_PTR_W  (SPLT_PTR_W),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_addr_dec (
        .addr   (i_icb_cmd_addr),
        .dec_id (dec_id)
    );

    assign cnt_zero = (outs_cnt == '0);
    // Switching targets only once everything is drained keeps responses in order.
    assign stall = (outs_cnt == OUTS_MAX) | (~cnt_zero & (dec_id != cur_id));

    always_comb begin
        tgt_ready = ~err_pend;
        o_bus_icb_cmd_valid = '0;
        for (int k = 0; k < SPLT_NUM; k++) begin
            if (dec_id == SPLT_PTR_W'(k)) begin
                tgt_ready = o_bus_icb_cmd_ready[k];
                o_bus_icb_cmd_valid[k] = i_icb_cmd_valid & ~stall;
            end
        end
    end

    assign i_icb_cmd_ready = tgt_ready & ~stall;
    assign cmd_hs = i_icb_cmd_valid & i_icb_cmd_ready;

    assign o_bus_icb_cmd_read  = {SPLT_NUM{i_icb_cmd_read}};
    assign o_bus_icb_cmd_addr  = {SPLT_NUM{i_icb_cmd_addr}};
    assign o_bus_icb_cmd_wdata = {SPLT_NUM{i_icb_cmd_wdata}};
    assign o_bus_icb_cmd_wmask = {SPLT_NUM{i_icb_cmd_wmask}};
    assign o_bus_icb_cmd_size  = {SPLT_NUM{i_icb_cmd_size}};
    assign o_bus_icb_cmd_lock  = {SPLT_NUM{i_icb_cmd_lock}};
    assign o_bus_icb_cmd_excl  = {SPLT_NUM{i_icb_cmd_excl}};
    assign o_bus_icb_cmd_usr   = {SPLT_NUM{i_icb_cmd_usr}};

    // With nothing outstanding, the only legal responder is the one being commanded now.
    assign rsp_open = ~cnt_zero | (ALLOW_0CYCL_RSP & cmd_hs);
    assign rsp_id = cnt_zero ? dec_id : cur_id;

    always_comb begin
        i_icb_rsp_valid = 1'b0;
        i_icb_rsp_err = 1'b0;
        i_icb_rsp_excl_ok = 1'b0;
        i_icb_rsp_rdata = '0;
        i_icb_rsp_usr = '0;
        o_bus_icb_rsp_ready = '0;
        if (rsp_open) begin
            if (rsp_id == ERR_ID) begin
                i_icb_rsp_valid = err_pend;
                i_icb_rsp_err = ERR_RSP_ERR;
                i_icb_rsp_excl_ok = ERR_RSP_EXCL_OK;
                i_icb_rsp_rdata = ERR_RDATA[DW-1:0];
                i_icb_rsp_usr = err_usr;
            end
            for (int k = 0; k < SPLT_NUM; k++) begin
                if (rsp_id == SPLT_PTR_W'(k)) begin
                    i_icb_rsp_valid = o_bus_icb_rsp_valid[k];
                    i_icb_rsp_err = o_bus_icb_rsp_err[k];
                    i_icb_rsp_excl_ok = o_bus_icb_rsp_excl_ok[k];
                    i_icb_rsp_rdata = o_bus_icb_rsp_rdata[k*DW +: DW];
                    i_icb_rsp_usr = o_bus_icb_rsp_usr[k*USR_W +: USR_W];
                    o_bus_icb_rsp_ready[k] = i_icb_rsp_ready;
                end
            end
        end
    end

    assign rsp_hs = i_icb_rsp_valid & i_icb_rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outs_cnt <= '0;
            cur_id <= '0;
            err_pend <= 1'b0;
            err_usr <= '0;
        end else begin
            if (cmd_hs) begin
                cur_id <= dec_id;
            end
            // The error target is never ready while pending, so set and clear never coincide.
            if (cmd_hs && (dec_id == ERR_ID)) begin
                err_pend <= 1'b1;
                err_usr <= i_icb_cmd_usr;
            end else if (rsp_hs && (rsp_id == ERR_ID)) begin
                err_pend <= 1'b0;
            end
            if (cmd_hs && !rsp_hs) begin
                outs_cnt <= outs_cnt + OUTS_CNT_W'(1);
            end else if (!cmd_hs && rsp_hs) begin
                outs_cnt <= outs_cnt - OUTS_CNT_W'(1);
            end
        end
    end

endmodule
